calc1_port_responder: RTL

//  DUV-side responder for one calc1 request port; the counterpart of the stimulus drivers.

---
 rtl/calc1_pkg.sv | 35 +++
 rtl/calc1_alu.sv | 39 +++
 rtl/calc1_port_responder.sv | 138 +++++++++++++
 3 files changed

// File: rtl/calc1_pkg.sv
// calc1 shared definitions: command and response codes, responder FSM
// encoding, the result record and the shift-amount helper. These are used by
// the port responder and by the drivers and checkers that talk to it.
package calc1_pkg;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_LSH = 4'd5;
    localparam logic [3:0] CMD_RSH = 4'd6;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_OVF  = 2'd2;
    localparam logic [1:0] RESP_INV  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP2  = 2'd1,
        ST_EXEC = 2'd2,
        ST_RESP = 2'd3
    } calc1_state_e;

    typedef struct packed {
        logic [1:0]  code;
        logic [31:0] data;
    } calc1_result_t;

    // Shift amount is the five least significant bits of operand2 (bit 0 is
    // the MSB in calc1 numbering); all upper bits are ignored.
    function automatic logic [4:0] calc1_shift_amount(input logic [0:31] op2);
        return op2[27:31];
    endfunction

endpackage

// File: rtl/calc1_alu.sv
// calc1 combinational execute unit: one command and two unsigned 32-bit
// operands in, response code and result data out.
module calc1_alu
    import calc1_pkg::*;
(
    input  logic [0:3]    cmd,
    input  logic [0:31]   op1,
    input  logic [0:31]   op2,
    output calc1_result_t result
);

    logic [32:0] sum_s;

    // Decode the command and form {code, data}; unsupported commands report invalid.
    always_comb begin
        sum_s  = {1'b0, op1} + {1'b0, op2};
        result = '{code: RESP_NONE, data: 32'd0};
        case (cmd)
            CMD_ADD: begin
                if (sum_s[32]) begin
                    result = '{code: RESP_OVF, data: 32'd0};
                end else begin
                    result = '{code: RESP_OK, data: sum_s[31:0]};
                end
            end
            CMD_SUB: begin
                if (op2 > op1) begin
                    result = '{code: RESP_OVF, data: 32'd0};
                end else begin
                    result = '{code: RESP_OK, data: op1 - op2};
                end
            end
            CMD_LSH: result = '{code: RESP_OK, data: op1 << calc1_shift_amount(op2)};
            CMD_RSH: result = '{code: RESP_OK, data: op1 >> calc1_shift_amount(op2)};
            default: result = '{code: RESP_INV, data: 32'd0};
        endcase
    end

endmodule

// File: rtl/calc1_port_responder.sv
// calc1 port responder: accepts a two-cycle request (cmd + operand1, then
// operand2), computes the result in the OP2 cycle, holds it for LATENCY
// cycles and presents a one-cycle response. The output register is loaded on
// the closing edge of RESP, so the response cycle itself lies in the cycle
// after RESP; a nonzero out_resp marks that cycle and blocks acceptance.
module calc1_port_responder
    import calc1_pkg::*;
#(
    parameter int unsigned LATENCY = 3,
    parameter int unsigned PORT_ID = 1
) (
    input  logic        c_clk,
    input  logic        reset_n,
    input  logic [0:3]  req_cmd_in,
    input  logic [0:31] req_data_in,
    output logic [0:1]  out_resp,
    output logic [0:31] out_data,
    output logic [0:2]  resp_port,
    output logic        busy,
    output logic        overlap_err
);

    if ((LATENCY < 1) || (LATENCY > 15)) begin : g_latency_check
        $error("calc1_port_responder: LATENCY %0d outside 1..15", LATENCY);
    end

    if ((PORT_ID < 1) || (PORT_ID > 4)) begin : g_port_id_check
        $error("calc1_port_responder: PORT_ID %0d outside 1..4", PORT_ID);
    end

    localparam logic [3:0] LAT_INIT   = 4'(LATENCY - 1);
    localparam bit         LAT_DIRECT = (LATENCY == 1);

    calc1_state_e  state_r;
    logic [3:0]    cmd_r;
    logic [31:0]   op1_r;
    logic [3:0]    cnt_r;
    calc1_result_t result_r;
    logic [1:0]    out_resp_r;
    logic [31:0]   out_data_r;
    logic          busy_r;
    logic          overlap_r;
    calc1_result_t alu_result_s;
    logic          cmd_valid_s;

    assign cmd_valid_s = (req_cmd_in != CMD_NOP);

    // Operand2 comes straight from the data bus during the OP2 cycle.
    calc1_alu u_alu (
        .cmd    (cmd_r),
        .op1    (op1_r),
        .op2    (req_data_in),
        .result (alu_result_s)
    );

    // Request FSM with operand latches, latency counter and registered outputs.
    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            cmd_r      <= 4'd0;
            op1_r      <= 32'd0;
            cnt_r      <= 4'd0;
            result_r   <= '{code: RESP_NONE, data: 32'd0};
            out_resp_r <= RESP_NONE;
            out_data_r <= 32'd0;
            busy_r     <= 1'b0;
            overlap_r  <= 1'b0;
        end else begin
            out_resp_r <= RESP_NONE;
            out_data_r <= 32'd0;
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid_s && (out_resp_r != RESP_NONE)) begin
                        // Response cycle: the port is still busy, refuse and flag.
                        overlap_r <= 1'b1;
                        busy_r    <= 1'b0;
                    end else if (cmd_valid_s) begin
                        cmd_r   <= req_cmd_in;
                        op1_r   <= req_data_in;
                        busy_r  <= 1'b1;
                        state_r <= ST_OP2;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_OP2: begin
                    if (cmd_valid_s) begin
                        overlap_r <= 1'b1;
                    end else begin
                        overlap_r <= overlap_r;
                    end
                    result_r <= alu_result_s;
                    cnt_r    <= LAT_INIT;
                    if (LAT_DIRECT) begin
                        state_r <= ST_RESP;
                    end else begin
                        state_r <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cmd_valid_s) begin
                        overlap_r <= 1'b1;
                    end else begin
                        overlap_r <= overlap_r;
                    end
                    cnt_r <= cnt_r - 4'd1;
                    if (cnt_r == 4'd1) begin
                        state_r <= ST_RESP;
                    end else begin
                        state_r <= ST_EXEC;
                    end
                end
                ST_RESP: begin
                    if (cmd_valid_s) begin
                        overlap_r <= 1'b1;
                    end else begin
                        overlap_r <= overlap_r;
                    end
                    out_resp_r <= result_r.code;
                    out_data_r <= result_r.data;
                    busy_r     <= 1'b1;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_resp    = out_resp_r;
    assign out_data    = out_data_r;
    assign resp_port   = 3'(PORT_ID);
    assign busy        = busy_r;
    assign overlap_err = overlap_r;

endmodule
